// File: rtl/xor_arb_pkg.sv
// Shared definitions for the XOR-unit arbiter: widths, state encoding, state enum.
package xor_arb_pkg;

  localparam int unsigned XOR_DATA_W  = 8;
  localparam int unsigned XOR_MAX_REQ = 4;
  localparam int unsigned GID_W       = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    EXEC = ST_EXEC,
    RESP = ST_RESP
  } state_e;

endpackage

// File: rtl/xor_share_arbiter_if.sv
// Requester-side bus of the shared XOR arbiter; master = requesters, slave = arbiter.
interface xor_share_arbiter_if
  import xor_arb_pkg::*;
#(
  parameter int unsigned DATA_W  = XOR_DATA_W,
  parameter int unsigned NUM_REQ = XOR_MAX_REQ
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] a_in;
  logic [NUM_REQ*DATA_W-1:0] b_in;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         result;
  logic [GID_W-1:0]          grant_id;
  logic                      busy;

  modport master (
    output req, a_in, b_in,
    input  ack, result, grant_id, busy
  );

  modport slave (
    input  req, a_in, b_in,
    output ack, result, grant_id, busy
  );

endinterface

// File: rtl/xor_component.sv
// Shared 8-bit bitwise XOR datapath.
module xor_component
  import xor_arb_pkg::*;
(
  input  logic [XOR_DATA_W-1:0] a,
  input  logic [XOR_DATA_W-1:0] b,
  output logic [XOR_DATA_W-1:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_share_arbiter.sv
// Arbitrates up to four requesters onto one xor_component; round-robin by default,
// fixed lowest-index priority when XOR_ARB_FIXED_PRIO_EN is defined.
module xor_share_arbiter
  import xor_arb_pkg::*;
#(
  parameter int unsigned DATA_W  = XOR_DATA_W,
  parameter int unsigned NUM_REQ = XOR_MAX_REQ
) (
  input logic                clk,
  input logic                rst,
  xor_share_arbiter_if.slave bus
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   xor_y;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [GID_W-1:0]    gid_q, gid_d;
  logic [GID_W-1:0]    winner;
  logic                busy_q, busy_d;

  function automatic logic [GID_W-1:0] wrap_inc(input logic [GID_W-1:0] i);
    return (32'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

`ifdef XOR_ARB_FIXED_PRIO_EN
  // Lowest set index wins; scanning downward leaves the lowest one last.
  function automatic logic [GID_W-1:0] pick(input logic [NUM_REQ-1:0] r);
    logic [GID_W-1:0] w;
    w = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (r[i]) w = GID_W'(i);
    end
    return w;
  endfunction

  assign winner = pick(bus.req);
`else
  logic [GID_W-1:0] ptr_q, ptr_d;

  // First set request scanning ptr, ptr+1, ... modulo NUM_REQ.
  function automatic logic [GID_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                            input logic [GID_W-1:0]   p);
    logic [GID_W-1:0] idx;
    logic [GID_W-1:0] w;
    logic             found;
    idx   = p;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
      idx = wrap_inc(idx);
    end
    return w;
  endfunction

  assign winner = pick(bus.req, ptr_q);
`endif

  xor_component u_xor (
    .a (op_a_q),
    .b (op_b_q),
    .y (xor_y)
  );

  // Next-state and next-register values.
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    ack_d    = '0;
    gid_d    = gid_q;
    busy_d   = busy_q;
`ifndef XOR_ARB_FIXED_PRIO_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          op_a_d  = bus.a_in[32'(winner)*DATA_W +: DATA_W];
          op_b_d  = bus.b_in[32'(winner)*DATA_W +: DATA_W];
          gid_d   = winner;
          busy_d  = 1'b1;
          state_d = EXEC;
`ifndef XOR_ARB_FIXED_PRIO_EN
          ptr_d   = wrap_inc(winner);
`endif
        end
      end
      EXEC: begin
        result_d = xor_y;
        ack_d    = NUM_REQ'(1) << gid_q;
        state_d  = RESP;
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      ack_q    <= '0;
      gid_q    <= '0;
      busy_q   <= 1'b0;
`ifndef XOR_ARB_FIXED_PRIO_EN
      ptr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      ack_q    <= ack_d;
      gid_q    <= gid_d;
      busy_q   <= busy_d;
`ifndef XOR_ARB_FIXED_PRIO_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign bus.ack      = ack_q;
  assign bus.result   = result_q;
  assign bus.grant_id = gid_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Directed bench for xor_share_arbiter: vector table plus multi-cycle sequences.
// Honours XOR_ARB_FIXED_PRIO_EN to select the matching expectations.
module tb_xor_share_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  xor_share_arbiter_if #(.DATA_W(8), .NUM_REQ(4)) bus ();

  xor_share_arbiter #(.DATA_W(8), .NUM_REQ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ack;
    logic [7:0]  res;
    logic [1:0]  gid;
  } vec_t;

  vec_t tv[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [31:0] a, input logic [31:0] b);
    bus.req  = r;
    bus.a_in = a;
    bus.b_in = b;
  endtask

  // Waits (bounded) on falling edges for a nonzero ack; n = edges waited.
  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ack == '0 && n < 8);
    if (bus.ack == '0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: no ack after %0d cycles", n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] cres[4];
    logic [3:0] eack;

    tv[0] = '{req:4'b0010, a:32'h0000A500, b:32'h00000F00, ack:4'b0010, res:8'hAA, gid:2'd1};
    tv[1] = '{req:4'b0001, a:32'h000000FF, b:32'h000000FF, ack:4'b0001, res:8'h00, gid:2'd0};
    tv[2] = '{req:4'b1000, a:32'h00000000, b:32'hFF000000, ack:4'b1000, res:8'hFF, gid:2'd3};
    tv[3] = '{req:4'b0100, a:32'h00550000, b:32'h00AA0000, ack:4'b0100, res:8'hFF, gid:2'd2};
    tv[4] = '{req:4'b0101, a:32'h00F00012, b:32'h000F0034, ack:4'b0001, res:8'h26, gid:2'd0};
`ifdef XOR_ARB_FIXED_PRIO_EN
    tv[5] = '{req:4'b0101, a:32'h00F00012, b:32'h000F0034, ack:4'b0001, res:8'h26, gid:2'd0};
`else
    tv[5] = '{req:4'b0101, a:32'h00F00012, b:32'h000F0034, ack:4'b0100, res:8'hFF, gid:2'd2};
`endif
    cres = '{8'h11, 8'h66, 8'h22, 8'hFC};

    rst = 1'b1;
    drive(4'b0000, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("reset_ack", 32'(bus.ack), 32'h0);
    check("reset_result", 32'(bus.result), 32'h0);
    check("reset_grant", 32'(bus.grant_id), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      drive(tv[i].req, tv[i].a, tv[i].b);
      wait_ack(n);
      check($sformatf("v%0d_latency", i), 32'(n), 32'd2);
      check($sformatf("v%0d_ack", i), 32'(bus.ack), 32'(tv[i].ack));
      check($sformatf("v%0d_result", i), 32'(bus.result), 32'(tv[i].res));
      check($sformatf("v%0d_grant", i), 32'(bus.grant_id), 32'(tv[i].gid));
      check($sformatf("v%0d_busy", i), 32'(bus.busy), 32'd1);
      bus.req = '0;
      @(negedge clk);
      check($sformatf("v%0d_ack_pulse", i), 32'(bus.ack), 32'h0);
      check($sformatf("v%0d_idle_busy", i), 32'(bus.busy), 32'd0);
      check($sformatf("v%0d_result_hold", i), 32'(bus.result), 32'(tv[i].res));
    end

    // Operands changed after the grant edge must not affect the result.
    drive(4'b0010, 32'h00003C00, 32'h0000C300);
    @(negedge clk);
    bus.a_in = 32'h00005A00;
    bus.b_in = 32'h00000000;
    wait_ack(n);
    check("late_op_result", 32'(bus.result), 32'hFF);
    check("late_op_ack", 32'(bus.ack), 32'h2);
    bus.req = '0;
    @(negedge clk);

    // Asynchronous reset during EXEC of requester 2 discards the op.
    drive(4'b0100, 32'h00110000, 32'h00220000);
    @(negedge clk);
    check("midrst_exec_busy", 32'(bus.busy), 32'd1);
    check("midrst_exec_grant", 32'(bus.grant_id), 32'd2);
    rst = 1'b1;
    #1;
    check("midrst_result", 32'(bus.result), 32'h0);
    check("midrst_grant", 32'(bus.grant_id), 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    check("midrst_ack", 32'(bus.ack), 32'h0);
    @(negedge clk);
    check("midrst_no_ack", 32'(bus.ack), 32'h0);
    rst = 1'b0;
    wait_ack(n);
    check("midrst_regrant_latency", 32'(n), 32'd2);
    check("midrst_regrant_ack", 32'(bus.ack), 32'h4);
    check("midrst_regrant_result", 32'(bus.result), 32'h33);
    check("midrst_regrant_grant", 32'(bus.grant_id), 32'd2);
    bus.req = '0;
    @(negedge clk);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

`ifdef XOR_ARB_FIXED_PRIO_EN
    // Requester 0 starves requester 2 until it drops its request.
    drive(4'b0101, 32'h00890001, 32'h00AB0010);
    for (int k = 0; k < 3; k++) begin
      wait_ack(n);
      check($sformatf("fp%0d_grant", k), 32'(bus.grant_id), 32'd0);
      check($sformatf("fp%0d_ack", k), 32'(bus.ack), 32'h1);
      check($sformatf("fp%0d_result", k), 32'(bus.result), 32'h11);
    end
    bus.req = 4'b0100;
    wait_ack(n);
    check("fp_late_grant", 32'(bus.grant_id), 32'd2);
    check("fp_late_ack", 32'(bus.ack), 32'h4);
    check("fp_late_result", 32'(bus.result), 32'h22);
`else
    // All four held: round-robin order 0,1,2,3,0, one ack every 3 cycles.
    drive(4'b1111, 32'hF0892301, 32'h0CAB4510);
    for (int k = 0; k < 5; k++) begin
      wait_ack(n);
      eack = 4'b0001 << (k % 4);
      check($sformatf("rr%0d_spacing", k), 32'(n), (k == 0) ? 32'd2 : 32'd3);
      check($sformatf("rr%0d_grant", k), 32'(bus.grant_id), 32'(k % 4));
      check($sformatf("rr%0d_ack", k), 32'(bus.ack), 32'(eack));
      check($sformatf("rr%0d_result", k), 32'(bus.result), 32'(cres[k % 4]));
    end
`endif
    bus.req = '0;
    repeat (3) @(negedge clk);
    check("final_idle_busy", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xor_share_arbiter.md
# xor_share_arbiter

Shares one 8-bit `xor_component` bitwise-XOR unit among up to four requesters. Arbitration is round-robin by default. The block latches the winner's operands, registers the XOR result, and returns it with a one-cycle acknowledge pulse. It sits between the ALU-side requesters (ALU op path, parity/checksum logic, test access) and the single shared XOR datapath.

## Interface
Parameters:
- `DATA_W`, default 8: operand width. Only 8 is supported, fixed by `xor_component`.
- `NUM_REQ`, default 4: number of requesters. Supported range is 2..4.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `req`  in  NUM_REQ: per-requester level request; bit i belongs to requester i.
- `a_in`  in  NUM_REQ*DATA_W: operand A; requester i occupies `[i*8+7:i*8]`.
- `b_in`  in  NUM_REQ*DATA_W: operand B, same packing as `a_in`.
- `ack`  out  NUM_REQ: one-hot, one-cycle completion pulse.
- `result`  out  DATA_W: XOR result; valid while `ack` is nonzero, then held.
- `grant_id`  out  2: index of the current or last granted requester.
- `busy`  out  1: high in EXEC and RESP.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If `req` is nonzero at a rising edge, select a winner.
  - Latch that winner's A and B into operand registers and set `grant_id`.
  - Go to EXEC. Otherwise stay in IDLE.
- EXEC: the operand registers drive `xor_component`. At the next edge, register its output into `result`, set `ack[grant_id]`, and go to RESP.
- RESP: `ack` is high for exactly this cycle. At the next edge, clear `ack` and return to IDLE.
- Round-robin:
  - A pointer `ptr` marks the highest-priority index.
  - The winner is the first set `req` bit scanning `ptr, ptr+1, …`, modulo NUM_REQ.
  - On grant, `ptr` becomes winner+1, modulo NUM_REQ, wrapping 3→0.
- Requester contract:
  - Hold `req` and operands stable until the grant edge.
  - Deassert `req` on the edge where `ack` is seen high; `req` is then low during the following IDLE cycle.
  - A requester that keeps `req` high gets another operation, with its operands re-latched.
- Boundary conditions:
  - `req` dropped before being sampled in IDLE: no grant, no ack.
  - `req` dropped during EXEC or RESP: the operation completes and `ack` still pulses, because operands are already latched.
  - Operand changes after the grant edge are ignored.
  - Simultaneous requests: exactly one grant per IDLE cycle. The others wait; no request is lost while held.
  - `rst` mid-operation: all state clears immediately and the in-flight op is discarded with no ack. A still-requesting master is re-arbitrated from `ptr=0`.
- Reset values:
  - state IDLE, `ptr` 0.
  - `ack`, `result`, `grant_id`, `busy` all 0.
  - Operand registers 0.

## Timing
- Request sampled at edge E0. EXEC spans E0–E1. `ack` and `result` are valid in the cycle after E1. The block is back in IDLE after E2.
- Latency: 2 cycles from the sampling edge to `ack`.
- Throughput: one op per 3 cycles when `req` is held continuously.
- `busy`: rises after E0, falls after E2.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `XOR_ARB_FIXED_PRIO_EN`.
- Defined: fixed priority, lowest index wins. `ptr` is not implemented (`ptr` logic compiled out), and requester 0 can starve the others.
- Undefined (default): round-robin as described above.

## Structure
- Shared package `xor_arb_pkg`:
  - state encoding localparams `ST_IDLE`=0, `ST_EXEC`=1, `ST_RESP`=2;
  - `XOR_DATA_W`=8;
  - `XOR_MAX_REQ`=4.
- One sub-module: the existing `xor_component`, instantiated once and fed from the operand registers.
- The winner-select function (round-robin or fixed priority) stays inline in the block.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `ack`=0, `result`=0x00, `grant_id`=0, `busy`=0 immediately.
- Single op: `req`=0010, a1=0xA5, b1=0x0F → `ack`=0010 two edges later, `result`=0xAA, `grant_id`=1, single-cycle pulse.
- Contention: `req`=1111 held, distinct operands → grants 0,1,2,3,0 in order, `ack` every 3 cycles, each result correct for its requester.
- Data corners: 0xFF^0xFF → 0x00; 0x00^0xFF → 0xFF; 0x55^0xAA → 0xFF. Also change operands after the grant edge → result is unchanged.
- Mid-op reset: assert `rst` during EXEC of requester 2 → no ack. After release with `req`=0100 held → re-granted, `ack`=0100 with the correct result.
- `XOR_ARB_FIXED_PRIO_EN` defined, `req`=0101 held → only requester 0 is acked; requester 2 is starved until `req[0]` drops, then acked on the next op.
